lcd_panel_sequencer: RTL and testbench
======================================

// Module: lcd_panel_sequencer
// PURPOSE
//  Panel power/enable controller in front of the LCD timing generator and LVDS path.
//  Steps the panel through the power-up order VDD -> signals -> backlight, and the
//  power-down order backlight -> signals -> VDD, with programmable delays.
//  Backlight-on and signal-off happen only on a frame boundary. A minimum off-time
//  is enforced before any re-power.
// PARAMETERS
//  T_VDD_SIG  default 50000   cycles from vdd_en high to timing_en/lvds_en high (>=1)
//  T_SIG_BL   default 200000  min cycles from signals on to bl_en high (>=1)
//  T_BL_SIG   default 200000  min cycles from bl_en low to signals off (>=1)
//  T_SIG_VDD  default 50000   cycles from signals off to vdd_en low (>=1)
//  T_OFF_MIN  default 500000  min cycles with vdd_en low before next power-up (>=1)
//  CW         default 24      delay counter width; every T_* must be < 2**CW
// PORTS
//  clock        in   1  system/pixel clock, rising edge
//  reset_L      in   1  asynchronous, active-low reset
//  power_req    in   1  level; 1 = panel wanted on, 0 = panel wanted off
//  frame_start  in   1  1-cycle pulse from timing generator at start of each frame
//  vdd_en       out  1  panel logic supply enable
//  timing_en    out  1  enable to HV timing generator
//  lvds_en      out  1  enable to LVDS serializer
//  bl_en        out  1  backlight enable
//  panel_on     out  1  1 only in state ON
//  busy         out  1  1 in any state other than OFF and ON
//  state        out  3  current state encoding (debug)
// BEHAVIOUR
//  Reset: state=OFF(0), delay counter=0, all outputs 0. Asynchronous, so it takes
//   effect even in mid-sequence.
//  Outputs are a Moore decode of the state register and change on the same edge as
//   the state. There is no combinational path from inputs to outputs.
//  Delay counter: cleared to 0 on every state change, then increments by 1 each cycle
//   and saturates at its limit. The delay is "done" when cnt==T-1, so a pure timed
//   state lasts exactly T cycles.
//  States (code: vdd/timing=lvds/bl):
//   OFF(0) 0/0/0      : power_req=1 -> PWR_UP.
//   PWR_UP(1) 1/0/0   : power_req=0 -> OFF_WAIT (abort); else after T_VDD_SIG -> SIG_UP.
//   SIG_UP(2) 1/1/0   : power_req=0 -> SIG_DN (abort, no frame wait);
//                       else if T_SIG_BL done AND frame_start -> ON.
//                       frame_start pulses before the delay is done are ignored.
//   ON(3) 1/1/1       : power_req=0 -> BL_DN.
//   BL_DN(4) 1/1/0    : when T_BL_SIG done AND frame_start -> SIG_DN.
//                       power_req is ignored here.
//   SIG_DN(5) 1/0/0   : after T_SIG_VDD -> OFF_WAIT.
//   OFF_WAIT(6) 0/0/0 : after T_OFF_MIN -> OFF.
//   Code 7 is illegal: go to OFF_WAIT with outputs 0/0/0.
//  Once a power-down has started (BL_DN, SIG_DN, OFF_WAIT), power_req is ignored
//   until OFF is reached. A power_req still high in OFF restarts power-up on the next edge.
//  Simultaneous events: in SIG_UP, power_req=0 has priority over frame_start.
//  If frame_start never arrives, the block waits in SIG_UP/BL_DN indefinitely.
//   No timeout.
//  panel_on = (state==ON). busy = (state!=OFF && state!=ON).
// TESTING (T_VDD_SIG=4, T_SIG_BL=6, T_BL_SIG=3, T_SIG_VDD=5, T_OFF_MIN=8)
//  1 Reset: hold reset_L=0, toggle power_req/frame_start
//    -> all outputs 0, state=0; deassert reset -> still OFF.
//  2 Power-up: power_req=1 at edge 0
//    -> vdd_en=1 from edge 0; timing_en=lvds_en=1 from edge 4;
//    frame_start at cycle 7 ignored; frame_start at cycle 12 -> bl_en=1, panel_on=1 after edge 12.
//  3 Power-down from ON: power_req=0
//    -> bl_en=0 next edge; signals drop on first frame_start >=3 cycles later;
//    vdd_en drops 5 cycles after that; busy=1 until OFF reached 8 cycles after that.
//  4 Abort in PWR_UP: power_req=0 at cycle 2 -> vdd_en=0 next edge, timing_en never 1,
//    state=6 for 8 cycles then 0.
//  5 Abort in SIG_UP and re-request: drop power_req in SIG_UP -> state 5;
//    reassert during 5/6 -> ignored; PWR_UP entered one edge after OFF.
//  6 Async reset mid-ON: pulse reset_L low between edges
//    -> all outputs 0 immediately; state=0.

Source files
------------

// File: rtl/lcd_panel_sequencer.sv
// Panel power/enable sequencer: VDD -> signals -> backlight up, reverse on the way down.
// Latency: outputs are registered Moore decodes and change on the same edge as the state.
// Backpressure: no handshake. The block waits indefinitely in SIG_UP/BL_DN for frame_start.
//
// Ports:
//   clock        rising-edge system/pixel clock
//   reset_L      asynchronous active-low reset (returns to OFF, all enables low)
//   power_req    level request: 1 = panel wanted on, 0 = panel wanted off
//   frame_start  single-cycle pulse at the start of each frame
//   vdd_en       panel logic supply enable
//   timing_en    HV timing generator enable
//   lvds_en      LVDS serializer enable (always equal to timing_en)
//   bl_en        backlight enable
//   panel_on     high only in ON
//   busy         high in any state other than OFF and ON
//   state        current state code (debug)
module lcd_panel_sequencer #(
    parameter int unsigned T_VDD_SIG = 50000,
    parameter int unsigned T_SIG_BL  = 200000,
    parameter int unsigned T_BL_SIG  = 200000,
    parameter int unsigned T_SIG_VDD = 50000,
    parameter int unsigned T_OFF_MIN = 500000,
    parameter int unsigned CW        = 24
) (
    input  logic          clock,
    input  logic          reset_L,
    input  logic          power_req,
    input  logic          frame_start,
    output logic          vdd_en,
    output logic          timing_en,
    output logic          lvds_en,
    output logic          bl_en,
    output logic          panel_on,
    output logic          busy,
    output logic [2:0]    state
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_PWR_UP   = 3'd1,
        S_SIG_UP   = 3'd2,
        S_ON       = 3'd3,
        S_BL_DN    = 3'd4,
        S_SIG_DN   = 3'd5,
        S_OFF_WAIT = 3'd6,
        S_ILLEGAL  = 3'd7
    } state_t;

    // "Done" is reached at cnt == T-1, so a pure timed state lasts exactly T cycles.
    localparam logic [CW-1:0] LIM_VDD_SIG = CW'(T_VDD_SIG - 1);
    localparam logic [CW-1:0] LIM_SIG_BL  = CW'(T_SIG_BL  - 1);
    localparam logic [CW-1:0] LIM_BL_SIG  = CW'(T_BL_SIG  - 1);
    localparam logic [CW-1:0] LIM_SIG_VDD = CW'(T_SIG_VDD - 1);
    localparam logic [CW-1:0] LIM_OFF_MIN = CW'(T_OFF_MIN - 1);

    state_t        cur_state;
    state_t        nxt_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_lim;
    logic          cnt_done;

    // Per-state delay limit. Untimed states use 0 so the counter stays parked at 0.
    always_comb begin
        cnt_lim = '0;
        case (cur_state)
            S_PWR_UP:   cnt_lim = LIM_VDD_SIG;
            S_SIG_UP:   cnt_lim = LIM_SIG_BL;
            S_BL_DN:    cnt_lim = LIM_BL_SIG;
            S_SIG_DN:   cnt_lim = LIM_SIG_VDD;
            S_OFF_WAIT: cnt_lim = LIM_OFF_MIN;
            default:    cnt_lim = '0;
        endcase
    end

    assign cnt_done = (cnt == cnt_lim);

    // Next-state rules. Once power-down begins (BL_DN onward) power_req is not
    // consulted again until OFF. In SIG_UP a dropped request beats frame_start,
    // and skips the frame wait because the backlight never came on.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_OFF: begin
                if (power_req) nxt_state = S_PWR_UP;
            end
            S_PWR_UP: begin
                if (!power_req)    nxt_state = S_OFF_WAIT;
                else if (cnt_done) nxt_state = S_SIG_UP;
            end
            S_SIG_UP: begin
                if (!power_req)                   nxt_state = S_SIG_DN;
                else if (cnt_done && frame_start) nxt_state = S_ON;
            end
            S_ON: begin
                if (!power_req) nxt_state = S_BL_DN;
            end
            S_BL_DN: begin
                if (cnt_done && frame_start) nxt_state = S_SIG_DN;
            end
            S_SIG_DN: begin
                if (cnt_done) nxt_state = S_OFF_WAIT;
            end
            S_OFF_WAIT: begin
                if (cnt_done) nxt_state = S_OFF;
            end
            default: begin
                // Corrupted code: treat as a fresh power-down so the off-time is honoured.
                nxt_state = S_OFF_WAIT;
            end
        endcase
    end

    // State, counter and registered output decode. Outputs are decoded from
    // nxt_state so they change on the same edge as the state register.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cur_state <= S_OFF;
            cnt       <= '0;
            vdd_en    <= 1'b0;
            timing_en <= 1'b0;
            lvds_en   <= 1'b0;
            bl_en     <= 1'b0;
            panel_on  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cur_state <= nxt_state;

            if (nxt_state != cur_state) begin
                cnt <= '0;
            end else if (!cnt_done) begin
                cnt <= cnt + CW'(1);
            end

            vdd_en    <= 1'b0;
            timing_en <= 1'b0;
            lvds_en   <= 1'b0;
            bl_en     <= 1'b0;
            panel_on  <= 1'b0;
            busy      <= 1'b1;
            case (nxt_state)
                S_OFF: begin
                    busy <= 1'b0;
                end
                S_PWR_UP: begin
                    vdd_en <= 1'b1;
                end
                S_SIG_UP: begin
                    vdd_en    <= 1'b1;
                    timing_en <= 1'b1;
                    lvds_en   <= 1'b1;
                end
                S_ON: begin
                    vdd_en    <= 1'b1;
                    timing_en <= 1'b1;
                    lvds_en   <= 1'b1;
                    bl_en     <= 1'b1;
                    panel_on  <= 1'b1;
                    busy      <= 1'b0;
                end
                S_BL_DN: begin
                    vdd_en    <= 1'b1;
                    timing_en <= 1'b1;
                    lvds_en   <= 1'b1;
                end
                S_SIG_DN: begin
                    vdd_en <= 1'b1;
                end
                default: begin
                    // OFF_WAIT and the illegal code: everything off, still busy.
                end
            endcase
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_lcd_panel_sequencer.sv
module tb_lcd_panel_sequencer;

    localparam int T_VDD_SIG = 4;
    localparam int T_SIG_BL  = 6;
    localparam int T_BL_SIG  = 3;
    localparam int T_SIG_VDD = 5;
    localparam int T_OFF_MIN = 8;

    logic       clock;
    logic       reset_L;
    logic       power_req;
    logic       frame_start;
    logic       vdd_en;
    logic       timing_en;
    logic       lvds_en;
    logic       bl_en;
    logic       panel_on;
    logic       busy;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Reference model: spec state code plus the edge index at which it was entered.
    int m_state = 0;
    int m_entry = 0;
    int cyc     = 0;

    lcd_panel_sequencer #(
        .T_VDD_SIG (T_VDD_SIG),
        .T_SIG_BL  (T_SIG_BL),
        .T_BL_SIG  (T_BL_SIG),
        .T_SIG_VDD (T_SIG_VDD),
        .T_OFF_MIN (T_OFF_MIN),
        .CW        (8)
    ) dut (
        .clock       (clock),
        .reset_L     (reset_L),
        .power_req   (power_req),
        .frame_start (frame_start),
        .vdd_en      (vdd_en),
        .timing_en   (timing_en),
        .lvds_en     (lvds_en),
        .bl_en       (bl_en),
        .panel_on    (panel_on),
        .busy        (busy),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected outputs {vdd, timing, lvds, bl, panel_on, busy} from the power-order table.
    function automatic logic [5:0] exp_outs(input int s);
        logic vdd, sig, bl;
        vdd = (s >= 1 && s <= 5);
        sig = (s >= 2 && s <= 4);
        bl  = (s == 3);
        return {vdd, sig, sig, bl, (s == 3), (s != 0 && s != 3)};
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    // A state is "timed out" once it has been occupied for at least T edges.
    function automatic void model_edge(input logic rst_l, input logic pr, input logic fs);
        int age;
        int nxt;
        age = cyc - m_entry;
        nxt = m_state;
        if (!rst_l) begin
            nxt = 0;
        end else begin
            case (m_state)
                0: if (pr) nxt = 1;
                1: nxt = !pr ? 6 : (age >= T_VDD_SIG ? 2 : 1);
                2: nxt = !pr ? 5 : ((age >= T_SIG_BL && fs) ? 3 : 2);
                3: if (!pr) nxt = 4;
                4: if (age >= T_BL_SIG && fs) nxt = 5;
                5: if (age >= T_SIG_VDD) nxt = 6;
                6: if (age >= T_OFF_MIN) nxt = 0;
                default: nxt = 6;
            endcase
        end
        if (nxt != m_state || !rst_l) m_entry = cyc;
        m_state = nxt;
        cyc++;
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_state"}, {6'd0, state}, 9'(m_state));
        chk({tag, "_outs"}, {3'd0, vdd_en, timing_en, lvds_en, bl_en, panel_on, busy},
            {3'd0, exp_outs(m_state)});
    endtask

    // One clock: model takes the inputs present at the edge; outputs sampled 1 unit later.
    task automatic step(input string tag);
        @(posedge clock);
        model_edge(reset_L, power_req, frame_start);
        #1;
        check_model(tag);
    endtask

    // Reset pulse between edges; outputs must clear without waiting for a clock.
    task automatic async_reset_pulse(input string tag);
        reset_L = 1'b0;
        #2;
        m_state = 0;
        m_entry = cyc;
        chk({tag, "_async_state"}, {6'd0, state}, 9'd0);
        chk({tag, "_async_outs"}, {3'd0, vdd_en, timing_en, lvds_en, bl_en, panel_on, busy}, 9'd0);
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L     = 1'b0;
        power_req   = 1'b0;
        frame_start = 1'b0;

        // 1: inputs wiggle under reset, nothing moves; released -> still OFF.
        for (int i = 0; i < 6; i++) begin
            power_req   = i[0];
            frame_start = i[1];
            step("t1_rst");
        end
        power_req   = 1'b0;
        frame_start = 1'b0;
        reset_L     = 1'b1;
        step("t1_rel");
        step("t1_rel");

        // 2: power-up; early frame_start (edge 7) ignored, edge 12 turns the backlight on.
        for (int k = 0; k <= 12; k++) begin
            power_req   = 1'b1;
            frame_start = (k == 7 || k == 12);
            step("t2_up");
            if (k == 3)  chk("t2_sig_low_e3", {8'd0, timing_en}, 9'd0);
            if (k == 4)  chk("t2_sig_high_e4", {8'd0, timing_en}, 9'd1);
            if (k == 7)  chk("t2_early_fs", {6'd0, state}, 9'd2);
        end
        chk("t2_on", {6'd0, state}, 9'd3);
        chk("t2_bl", {7'd0, bl_en, panel_on}, 9'd3);
        frame_start = 1'b0;
        step("t2_hold");

        // 3: power-down from ON; one early frame then a qualifying one.
        power_req = 1'b0;
        for (int k = 0; k < 30; k++) begin
            frame_start = (k == 1 || k == 5);
            step("t3_dn");
        end
        chk("t3_off", {6'd0, state}, 9'd0);

        // 4: abort during PWR_UP after two cycles.
        for (int k = 0; k < 14; k++) begin
            power_req   = (k < 2);
            frame_start = 1'b0;
            step("t4_abort");
            if (k >= 2 && k < 10) chk("t4_wait", {6'd0, state}, 9'd6);
        end

        // 5: abort from SIG_UP, then reassert during SIG_DN/OFF_WAIT.
        power_req = 1'b1;
        for (int k = 0; k < 6; k++) step("t5_up");
        chk("t5_in_sig_up", {6'd0, state}, 9'd2);
        power_req = 1'b0;
        step("t5_abort");
        chk("t5_sig_dn", {6'd0, state}, 9'd5);
        power_req = 1'b1;
        for (int k = 0; k < 20; k++) step("t5_rereq");

        // 6: reach ON then hit an async reset mid-cycle.
        for (int k = 0; k < 12; k++) begin
            frame_start = (k % 4 == 3);
            step("t6_up");
        end
        frame_start = 1'b0;
        chk("t6_on", {6'd0, state}, 9'd3);
        async_reset_pulse("t6");
        power_req = 1'b0;
        step("t6_after");

        // Randomized run against the model, including occasional async resets.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 24) == 0) power_req = ~power_req;
            frame_start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 599) == 0) async_reset_pulse("rnd");
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
